dmux16_router: RTL and testbench
================================

DMUX16_ROUTER -- requirements
Module: dmux16_router

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter CNTW, default 8, width of each per-output transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  word to be routed.
REQ-006 in_sel  input  1  route select: 0 = port a, 1 = port b.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  router accepts the offered word this cycle.
REQ-009 a_data  output  WIDTH  buffered word for port a.
REQ-010 a_valid  output  1  a_data holds an undelivered word.
REQ-011 a_ready  input  1  port a consumer accepts a_data.
REQ-012 b_data  output  WIDTH  buffered word for port b.
REQ-013 b_valid  output  1  b_data holds an undelivered word.
REQ-014 b_ready  input  1  port b consumer accepts b_data.
REQ-015 a_count  output  CNTW  number of words delivered on port a, saturating.
REQ-016 b_count  output  CNTW  number of words delivered on port b, saturating.

Function
REQ-017 Each output port has one single-entry holding register (data + valid flag).
REQ-018 Input transfer occurs on a rising edge when in_valid=1 and in_ready=1.
REQ-019 Output transfer on port p occurs on a rising edge when p_valid=1 and p_ready=1.
REQ-020 in_ready is combinational: 1 when the register selected by in_sel is empty OR is transferring out in the same cycle.
REQ-021 in_ready is independent of the non-selected port's state; a stalled port never blocks traffic to the other port.
REQ-022 On an input transfer, in_data loads into the selected port's register and its valid flag is set; latency from input transfer to p_valid=1 is 1 cycle.
REQ-023 Simultaneous output transfer and input transfer on the same port: the register reloads with the new word, and valid stays 1 (full throughput of 1 word/cycle per port).
REQ-024 Output transfer with no input transfer to that port: the valid flag clears; p_data keeps its last value.
REQ-025 The non-selected port's register is never written by an input transfer.
REQ-026 p_data and p_valid remain stable while p_valid=1 and p_ready=0.
REQ-027 p_count increments by 1 on each output transfer on port p and holds at 2^CNTW-1 (no wrap-around).
REQ-028 in_sel and in_data are ignored when in_valid=0; in_ready may be 1 regardless of in_valid.
REQ-029 Words are delivered on each port in the order in which they were accepted for that port.

Reset
REQ-030 While rst_n=0: a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0, in_ready=0.
REQ-031 Reset asserts asynchronously; any buffered word is discarded and is not counted.
REQ-032 After rst_n deasserts, in_ready=1 for either in_sel value; the first transfer is possible on the first rising edge with rst_n=1.

Verification
REQ-033 Reset: rst_n=0 mid-stream with a_valid=1 -> a_valid, b_valid, counts, data all 0 immediately, before the next clk edge.
REQ-034 Routing: in_data=16'hBEEF, in_sel=0, in_valid=1, a_ready=b_ready=1 -> next cycle a_valid=1, a_data=16'hBEEF, b_valid=0; following edge a_count=1.
REQ-035 Isolation: b_ready=0 with b full (b_data=16'h1234); offer in_sel=1 -> in_ready=0; offer in_sel=0, 16'h0001 -> in_ready=1, a receives 16'h0001; b_data remains 16'h1234.
REQ-036 Throughput: 10 back-to-back words 16'h0000..16'h0009 to port a, a_ready=1 -> in_ready=1 every cycle, words appear in order on consecutive cycles, a_count=10.
REQ-037 Pass-through: a full, a_ready=1 and new word 16'hCAFE offered to a in the same cycle -> in_ready=1, next cycle a_valid=1 and a_data=16'hCAFE.
REQ-038 Saturation: 300 transfers on port b with CNTW=8 -> b_count=255 and remains 255.

Source files
------------

// File: rtl/dmux16_router.sv
// dmux16_router: 1-to-2 demux with single-entry hold buffer per output port.
// Ports: clk/rst_n, in_* (valid/ready input), a_*/b_* (valid/ready outputs), a_count/b_count.
module dmux16_router #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNTW-1:0]  a_count,
  output logic [CNTW-1:0]  b_count
);

  logic [WIDTH-1:0] r_a_data;
  logic [WIDTH-1:0] r_b_data;
  logic             r_a_valid;
  logic             r_b_valid;
  logic [CNTW-1:0]  r_a_cnt;
  logic [CNTW-1:0]  r_b_cnt;

  logic w_a_out;
  logic w_b_out;
  logic w_a_room;
  logic w_b_room;
  logic w_a_in;
  logic w_b_in;

  assign w_a_out  = r_a_valid & a_ready;
  assign w_b_out  = r_b_valid & b_ready;
  // A port has room if empty or draining this same cycle.
  assign w_a_room = ~r_a_valid | a_ready;
  assign w_b_room = ~r_b_valid | b_ready;
  // Only the selected port gates the input; held low during reset.
  assign in_ready = rst_n & (in_sel ? w_b_room : w_a_room);
  assign w_a_in   = in_valid & in_ready & ~in_sel;
  assign w_b_in   = in_valid & in_ready & in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_data  <= '0;
      r_a_valid <= 1'b0;
    end else if (w_a_in) begin
      r_a_data  <= in_data;
      r_a_valid <= 1'b1;
    end else if (w_a_out) begin
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_data  <= '0;
      r_b_valid <= 1'b0;
    end else if (w_b_in) begin
      r_b_data  <= in_data;
      r_b_valid <= 1'b1;
    end else if (w_b_out) begin
      r_b_valid <= 1'b0;
    end
  end

  // Saturating delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_a_out && (r_a_cnt != '1))
        r_a_cnt <= r_a_cnt + 1'b1;
      if (w_b_out && (r_b_cnt != '1))
        r_b_cnt <= r_b_cnt + 1'b1;
    end
  end

  assign a_data  = r_a_data;
  assign a_valid = r_a_valid;
  assign b_data  = r_b_data;
  assign b_valid = r_b_valid;
  assign a_count = r_a_cnt;
  assign b_count = r_b_cnt;

endmodule

// File: tb/tb_dmux16_router.sv
// tb_dmux16_router: directed self-checking bench for dmux16_router.
// Drives inputs 1ns after rising edges; checks registered outputs there too.
module tb_dmux16_router;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  a_count;
  logic [7:0]  b_count;

  int nvec;
  int nerr;

  dmux16_router #(.WIDTH(16), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    nvec++;
    if ({a_valid, b_valid, a_data, b_data, a_count, b_count} !== '0) begin
      nerr++;
      $display("FAIL reset_state got av=%b bv=%b ad=%h bd=%h ac=%0d bc=%0d want all 0",
               a_valid, b_valid, a_data, b_data, a_count, b_count);
    end
    rst_n = 1'b1;
    #1;
    in_sel = 1'b0; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL post_reset_ready_a got %b want 1", in_ready);
    end
    in_sel = 1'b1; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL post_reset_ready_b got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_route();
    in_valid = 1'b0; in_sel = 1'b1; in_data = 16'h7777;
    tick();
    nvec++;
    if ({a_valid, b_valid} !== 2'b00) begin
      nerr++; $display("FAIL ignore_invalid got av=%b bv=%b want 0 0", a_valid, b_valid);
    end
    in_data = 16'hBEEF; in_sel = 1'b0; in_valid = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (a_valid !== 1'b1 || a_data !== 16'hBEEF || b_valid !== 1'b0) begin
      nerr++;
      $display("FAIL route_a got av=%b ad=%h bv=%b want 1 beef 0", a_valid, a_data, b_valid);
    end
    tick();
    nvec++;
    if (a_count !== 8'd1 || a_valid !== 1'b0) begin
      nerr++; $display("FAIL route_count got ac=%0d av=%b want 1 0", a_count, a_valid);
    end
  endtask

  task automatic test_isolation();
    b_ready = 1'b0; a_ready = 1'b1;
    in_data = 16'h1234; in_sel = 1'b1; in_valid = 1'b1;
    tick();
    nvec++;
    if (b_valid !== 1'b1 || b_data !== 16'h1234) begin
      nerr++; $display("FAIL iso_load_b got bv=%b bd=%h want 1 1234", b_valid, b_data);
    end
    in_data = 16'h5555; in_sel = 1'b1; #1;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL iso_b_block got %b want 0", in_ready);
    end
    in_data = 16'h0001; in_sel = 1'b0; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL iso_a_open got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    nvec++;
    if (a_valid !== 1'b1 || a_data !== 16'h0001) begin
      nerr++; $display("FAIL iso_a_recv got av=%b ad=%h want 1 0001", a_valid, a_data);
    end
    nvec++;
    if (b_valid !== 1'b1 || b_data !== 16'h1234) begin
      nerr++; $display("FAIL iso_b_hold got bv=%b bd=%h want 1 1234", b_valid, b_data);
    end
    tick();
    b_ready = 1'b1;
    tick();
    nvec++;
    if (b_count !== 8'd1 || b_valid !== 1'b0 || b_data !== 16'h1234) begin
      nerr++;
      $display("FAIL iso_b_drain got bc=%0d bv=%b bd=%h want 1 0 1234", b_count, b_valid, b_data);
    end
  endtask

  task automatic test_midstream_reset();
    a_ready = 1'b0;
    in_data = 16'hA5A5; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (a_valid !== 1'b1) begin
      nerr++; $display("FAIL mid_pre got av=%b want 1", a_valid);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({a_valid, b_valid, a_data, b_data, a_count, b_count, in_ready} !== '0) begin
      nerr++;
      $display("FAIL mid_reset got av=%b bv=%b ad=%h bd=%h ac=%0d bc=%0d rdy=%b want all 0",
               a_valid, b_valid, a_data, b_data, a_count, b_count, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    a_ready = 1'b1;
    in_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 16'(i); in_valid = 1'b1; #1;
      nvec++;
      if (in_ready !== 1'b1) begin
        nerr++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
      end
      tick();
      nvec++;
      if (a_valid !== 1'b1 || a_data !== 16'(i)) begin
        nerr++; $display("FAIL b2b_word[%0d] got av=%b ad=%h want 1 %h", i, a_valid, a_data, 16'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    nvec++;
    if (a_count !== 8'd10) begin
      nerr++; $display("FAIL b2b_count got %0d want 10", a_count);
    end
  endtask

  task automatic test_passthrough();
    a_ready = 1'b0;
    in_data = 16'h1111; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 16'h2222;
    tick();
    tick();
    nvec++;
    if (a_valid !== 1'b1 || a_data !== 16'h1111) begin
      nerr++; $display("FAIL stall_hold got av=%b ad=%h want 1 1111", a_valid, a_data);
    end
    a_ready = 1'b1; in_data = 16'hCAFE; #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL pass_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    nvec++;
    if (a_valid !== 1'b1 || a_data !== 16'hCAFE || a_count !== 8'd11) begin
      nerr++;
      $display("FAIL pass_data got av=%b ad=%h ac=%0d want 1 cafe 11", a_valid, a_data, a_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    pulse_reset();
    b_ready = 1'b1; in_sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    nvec++;
    if (b_count !== 8'd255) begin
      nerr++; $display("FAIL sat_reach got %0d want 255", b_count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    nvec++;
    if (b_count !== 8'd255 || a_count !== 8'd0) begin
      nerr++; $display("FAIL sat_hold got bc=%0d ac=%0d want 255 0", b_count, a_count);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_route();
    test_isolation();
    test_midstream_reset();
    test_back_to_back();
    test_passthrough();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
